leaf_out_arbiter: RTL and testbench



---
 rtl/leaf_pkg.sv | 28 ++
 rtl/leaf_out_arbiter_if.sv | 23 ++
 rtl/leaf_rr_arbiter.sv | 44 ++++
 rtl/leaf_out_arbiter.sv | 132 +++++++++++++
 tb/tb_leaf_out_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leaf_pkg.sv
// Shared packet field widths, packet width derivation and packet assembly
// for the leaf output arbiter.
package leaf_pkg;

    localparam int LEAF_PAYLOAD_BITS_DEF = 32;
    localparam int LEAF_LEAF_BITS_DEF    = 5;
    localparam int LEAF_PORT_BITS_DEF    = 4;
    localparam int LEAF_ADDR_BITS_DEF    = 7;

    function automatic int packet_bits(int leaf_bits, int port_bits, int addr_bits,
                                       int payload_bits);
        return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
    endfunction

    localparam int LEAF_PACKET_BITS_DEF = packet_bits(LEAF_LEAF_BITS_DEF, LEAF_PORT_BITS_DEF,
                                                      LEAF_ADDR_BITS_DEF, LEAF_PAYLOAD_BITS_DEF);

    // Layout MSB..LSB: valid, leaf, dport, addr, payload.
    function automatic logic [LEAF_PACKET_BITS_DEF-1:0] make_packet(
        logic [LEAF_LEAF_BITS_DEF-1:0]    leaf,
        logic [LEAF_PORT_BITS_DEF-1:0]    dport,
        logic [LEAF_ADDR_BITS_DEF-1:0]    addr,
        logic [LEAF_PAYLOAD_BITS_DEF-1:0] payload
    );
        return {1'b1, leaf, dport, addr, payload};
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// User-side stream bundle of the leaf output arbiter: payloads, valids, capture
// acks, resend stall and the registered packet toward the fabric.
interface leaf_out_arbiter_if #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_OUT_PORTS = 7,
    parameter int PACKET_BITS   = 49
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
    logic                                  resend;
    logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;

    modport master (
        output din_leaf_user2interface, vld_user2interface, resend,
        input  ack_interface2user, dout_leaf_interface2bft
    );

    modport slave (
        input  din_leaf_user2interface, vld_user2interface, resend,
        output ack_interface2user, dout_leaf_interface2bft
    );
endinterface

// File: rtl/leaf_rr_arbiter.sv
// One-hot request arbiter. LEAF_OUT_RR_EN selects round-robin; otherwise the
// search pointer stays at index 0, which is fixed priority with the lowest index winning.
module leaf_rr_arbiter #(
    parameter int NUM_REQ = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_BITS-1:0] ptr_q, ptr_d;
    logic                found;
    int                  win;
    int                  idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        win   = 0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) gnt[win] = 1'b1;

        ptr_d = ptr_q;
`ifdef LEAF_OUT_RR_EN
        if (found) ptr_d = (win == NUM_REQ - 1) ? '0 : PTR_BITS'(win + 1);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Arbitrates user output streams onto one fabric packet port, with a route table,
// per-port write addresses and receiver credits. LEAF_OUT_RR_EN selects round-robin arbitration.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS          = LEAF_PAYLOAD_BITS_DEF,
    parameter int NUM_LEAF_BITS         = LEAF_LEAF_BITS_DEF,
    parameter int NUM_PORT_BITS         = LEAF_PORT_BITS_DEF,
    parameter int NUM_ADDR_BITS         = LEAF_ADDR_BITS_DEF,
    parameter int NUM_OUT_PORTS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    localparam int PACKET_BITS = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS,
                                             PAYLOAD_BITS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [NUM_PORT_BITS-1:0] cfg_port,
    input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dport,
    input  logic                     credit_vld,
    input  logic [NUM_PORT_BITS-1:0] credit_port,
    leaf_out_arbiter_if.slave        bus
);
    localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
    localparam int CREDIT_MAX  = 2 ** NUM_ADDR_BITS;

    logic [NUM_ADDR_BITS-1:0] addr_q        [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_d        [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_q      [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_d      [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] route_leaf_q  [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] route_leaf_d  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] route_dport_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] route_dport_d [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] route_vld_q, route_vld_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;

    logic [NUM_OUT_PORTS-1:0] req, gnt;
    logic [NUM_LEAF_BITS-1:0] sel_leaf;
    logic [NUM_PORT_BITS-1:0] sel_dport;
    logic [NUM_ADDR_BITS-1:0] sel_addr;
    logic [PAYLOAD_BITS-1:0]  sel_payload;
    logic [PACKET_BITS-1:0]   pkt;
    int unsigned              cr_sum;

    // Eligibility looks only at registered route/credit state, so same-cycle
    // config writes and credit returns take effect from the next cycle.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            req[i] = bus.vld_user2interface[i] && route_vld_q[i] && (credit_q[i] != '0)
                     && !bus.resend && !reset;
        end
    end

    leaf_rr_arbiter #(
        .NUM_REQ (NUM_OUT_PORTS)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus.ack_interface2user      = gnt;
    assign bus.dout_leaf_interface2bft = dout_q;

    always_comb begin
        sel_leaf    = '0;
        sel_dport   = '0;
        sel_addr    = '0;
        sel_payload = '0;
        cr_sum      = 0;
        route_vld_d = route_vld_q;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            addr_d[i]        = addr_q[i];
            route_leaf_d[i]  = route_leaf_q[i];
            route_dport_d[i] = route_dport_q[i];

            cr_sum = 32'(credit_q[i]);
            if (credit_vld && (int'(credit_port) == i + 1)) cr_sum = cr_sum + FREESPACE_UPDATE_SIZE;
            if (gnt[i]) begin
                cr_sum      = cr_sum - 1;
                addr_d[i]   = addr_q[i] + 1'b1;
                sel_leaf    = route_leaf_q[i];
                sel_dport   = route_dport_q[i];
                sel_addr    = addr_q[i];
                sel_payload = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
            credit_d[i] = (cr_sum > CREDIT_MAX) ? CREDIT_BITS'(CREDIT_MAX) : CREDIT_BITS'(cr_sum);

            if (cfg_we && (int'(cfg_port) == i + 1)) begin
                route_vld_d[i]   = 1'b1;
                route_leaf_d[i]  = cfg_leaf;
                route_dport_d[i] = cfg_dport;
            end
        end
        dout_d = (|gnt) ? pkt : '0;
    end

    // The package helper is sized for the default field widths.
    if (PAYLOAD_BITS == LEAF_PAYLOAD_BITS_DEF && NUM_LEAF_BITS == LEAF_LEAF_BITS_DEF &&
        NUM_PORT_BITS == LEAF_PORT_BITS_DEF && NUM_ADDR_BITS == LEAF_ADDR_BITS_DEF) begin : g_pkt_pkg
        assign pkt = make_packet(sel_leaf, sel_dport, sel_addr, sel_payload);
    end else begin : g_pkt_generic
        assign pkt = {1'b1, sel_leaf, sel_dport, sel_addr, sel_payload};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q      <= '0;
            route_vld_q <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                addr_q[i]        <= '0;
                credit_q[i]      <= CREDIT_BITS'(CREDIT_MAX);
                route_leaf_q[i]  <= '0;
                route_dport_q[i] <= '0;
            end
        end else begin
            dout_q      <= dout_d;
            route_vld_q <= route_vld_d;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                addr_q[i]        <= addr_d[i];
                credit_q[i]      <= credit_d[i];
                route_leaf_q[i]  <= route_leaf_d[i];
                route_dport_q[i] <= route_dport_d[i];
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed self-checking bench for leaf_out_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for credit exhaustion, arbitration order, resend and reset.
module tb_leaf_out_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [3:0] cfg_port;
    logic [4:0] cfg_leaf;
    logic [3:0] cfg_dport;
    logic       credit_vld;
    logic [3:0] credit_port;

    int n_cmp  = 0;
    int n_fail = 0;

    leaf_out_arbiter_if #(.PAYLOAD_BITS(32), .NUM_OUT_PORTS(7), .PACKET_BITS(49)) bus ();

    leaf_out_arbiter #(
        .PAYLOAD_BITS          (32),
        .NUM_LEAF_BITS         (5),
        .NUM_PORT_BITS         (4),
        .NUM_ADDR_BITS         (7),
        .NUM_OUT_PORTS         (7),
        .FREESPACE_UPDATE_SIZE (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_port    (cfg_port),
        .cfg_leaf    (cfg_leaf),
        .cfg_dport   (cfg_dport),
        .credit_vld  (credit_vld),
        .credit_port (credit_port),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg_we;
        logic [3:0]  cfg_port;
        logic [4:0]  cfg_leaf;
        logic [3:0]  cfg_dport;
        logic [6:0]  vld;
        logic [31:0] pay1;
        logic [31:0] pay2;
        logic        resend;
        logic        cr_vld;
        logic [3:0]  cr_port;
        logic [6:0]  exp_ack;
        logic [48:0] exp_dout;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [48:0] mkpkt(int leaf, int dport, int addr, logic [31:0] pay);
        logic [4:0] l;
        logic [3:0] d;
        logic [6:0] a;
        l = 5'(leaf);
        d = 4'(dport);
        a = 7'(addr);
        return {1'b1, l, d, a, pay};
    endfunction

    function automatic vec_t mkvec(logic we, int cp, int cl, int cd, logic [6:0] vld,
                                   logic [31:0] p1, logic [31:0] p2, logic rs, logic crv,
                                   int crp, logic [6:0] eack, logic [48:0] edout);
        vec_t v;
        v.cfg_we = we;    v.cfg_port = 4'(cp); v.cfg_leaf = 5'(cl); v.cfg_dport = 4'(cd);
        v.vld = vld;      v.pay1 = p1;         v.pay2 = p2;         v.resend = rs;
        v.cr_vld = crv;   v.cr_port = 4'(crp); v.exp_ack = eack;    v.exp_dout = edout;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [6:0] vld, logic [31:0] p1, logic [31:0] p2);
        bus.vld_user2interface      = vld;
        bus.din_leaf_user2interface = {160'd0, p2, p1};
    endtask

    task automatic idle();
        cfg_we = 1'b0; cfg_port = '0; cfg_leaf = '0; cfg_dport = '0;
        credit_vld = 1'b0; credit_port = '0;
        bus.resend = 1'b0;
        drive(7'd0, 32'd0, 32'd0);
    endtask

    // Samples the combinational ack, then advances to just after the next edge.
    task automatic cycle(output logic [6:0] ack_s);
        #1 ack_s = bus.ack_interface2user;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [6:0] a;
        idle();
        reset = 1'b1;
        cycle(a);
        reset = 1'b0;
    endtask

    task automatic cfg(int port, int leaf, int dport);
        logic [6:0] a;
        idle();
        cfg_we = 1'b1; cfg_port = 4'(port); cfg_leaf = 5'(leaf); cfg_dport = 4'(dport);
        cycle(a);
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ack_s;
        int         exp_addr;
        int         grants;
        logic [6:0] exp_ack;

        // Reset state: no ack even with every valid high, blank output.
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        drive(7'h7f, 32'h1, 32'h2);
        cycle(ack_s);
        chk("reset_ack", 64'(ack_s), 64'd0);
        chk("reset_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        reset = 1'b0;
        idle();
        cycle(ack_s);
        chk("post_reset_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);

        // Vector table.
        tbl[0] = mkvec(0, 0, 0, 0, 7'b0000000, 0, 0, 0, 0, 0, 7'b0000000, 49'd0);
        tbl[1] = mkvec(0, 0, 0, 0, 7'b0000001, 32'hAAAA0001, 0, 0, 0, 0, 7'b0000000, 49'd0);
        tbl[2] = mkvec(1, 1, 3, 2, 7'b0000001, 32'hAAAA0002, 0, 0, 0, 0, 7'b0000000, 49'd0);
        tbl[3] = mkvec(0, 0, 0, 0, 7'b0000001, 32'hDEADBEEF, 0, 0, 0, 0, 7'b0000001,
                       mkpkt(3, 2, 0, 32'hDEADBEEF));
        tbl[4] = mkvec(1, 2, 7, 5, 7'b0000011, 32'hCAFEF00D, 32'h12345678, 0, 0, 0, 7'b0000001,
                       mkpkt(3, 2, 1, 32'hCAFEF00D));
`ifdef LEAF_OUT_RR_EN
        tbl[5] = mkvec(0, 0, 0, 0, 7'b0000011, 32'h55, 32'h66, 0, 0, 0, 7'b0000010,
                       mkpkt(7, 5, 0, 32'h66));
        tbl[6] = mkvec(0, 0, 0, 0, 7'b0000010, 0, 32'h77, 0, 0, 0, 7'b0000010,
                       mkpkt(7, 5, 1, 32'h77));
`else
        tbl[5] = mkvec(0, 0, 0, 0, 7'b0000011, 32'h55, 32'h66, 0, 0, 0, 7'b0000001,
                       mkpkt(3, 2, 2, 32'h55));
        tbl[6] = mkvec(0, 0, 0, 0, 7'b0000010, 0, 32'h77, 0, 0, 0, 7'b0000010,
                       mkpkt(7, 5, 0, 32'h77));
`endif
        tbl[7] = mkvec(1, 0, 1, 1, 7'b0000100, 0, 0, 0, 1, 0, 7'b0000000, 49'd0);
        tbl[8] = mkvec(1, 8, 1, 1, 7'b0000100, 0, 0, 0, 1, 8, 7'b0000000, 49'd0);
        tbl[9] = mkvec(0, 0, 0, 0, 7'b0000011, 32'h99, 32'h98, 1, 0, 0, 7'b0000000, 49'd0);
`ifdef LEAF_OUT_RR_EN
        exp_addr = 2;
`else
        exp_addr = 3;
`endif
        tbl[10] = mkvec(1, 1, 9, 4, 7'b0000001, 32'h11111111, 0, 0, 0, 0, 7'b0000001,
                        mkpkt(3, 2, exp_addr, 32'h11111111));
        tbl[11] = mkvec(0, 0, 0, 0, 7'b0000001, 32'h22222222, 0, 0, 0, 0, 7'b0000001,
                        mkpkt(9, 4, exp_addr + 1, 32'h22222222));

        for (int i = 0; i < 12; i++) begin
            cfg_we = tbl[i].cfg_we; cfg_port = tbl[i].cfg_port;
            cfg_leaf = tbl[i].cfg_leaf; cfg_dport = tbl[i].cfg_dport;
            credit_vld = tbl[i].cr_vld; credit_port = tbl[i].cr_port;
            bus.resend = tbl[i].resend;
            drive(tbl[i].vld, tbl[i].pay1, tbl[i].pay2);
            cycle(ack_s);
            chk($sformatf("vec%0d_ack", i), 64'(ack_s), 64'(tbl[i].exp_ack));
            chk($sformatf("vec%0d_dout", i), 64'(bus.dout_leaf_interface2bft),
                64'(tbl[i].exp_dout));
        end
        idle();

        // Credit exhaustion on port 1, then one credit return and address wrap.
        do_reset();
        cfg(1, 3, 2);
        exp_addr = 0;
        grants = 0;
        for (int c = 0; c < 140; c++) begin
            drive(7'b0000001, 32'(c), 0);
            cycle(ack_s);
            if (ack_s[0]) begin
                chk("s1_pkt", 64'(bus.dout_leaf_interface2bft), 64'(mkpkt(3, 2, exp_addr, 32'(c))));
                exp_addr = (exp_addr + 1) % 128;
                grants++;
            end
        end
        chk("s1_grants", 64'(grants), 64'd128);
        credit_vld = 1'b1; credit_port = 4'd1;
        drive(7'b0000001, 32'h5A5A, 0);
        cycle(ack_s);
        chk("s1_ack_at_credit", 64'(ack_s), 64'd0);
        credit_vld = 1'b0;
        grants = 0;
        for (int c = 0; c < 80; c++) begin
            drive(7'b0000001, 32'(1000 + c), 0);
            cycle(ack_s);
            if (ack_s[0]) begin
                chk("s1_wrap_pkt", 64'(bus.dout_leaf_interface2bft),
                    64'(mkpkt(3, 2, exp_addr, 32'(1000 + c))));
                exp_addr = (exp_addr + 1) % 128;
                grants++;
            end
        end
        chk("s1_credit_grants", 64'(grants), 64'd64);

        // Arbitration order with ports 1..3 always valid.
        do_reset();
        cfg(1, 1, 1);
        cfg(2, 2, 2);
        cfg(3, 3, 3);
        for (int k = 0; k < 6; k++) begin
            drive(7'b0000111, 32'(k), 32'(k));
            cycle(ack_s);
`ifdef LEAF_OUT_RR_EN
            exp_ack = 7'(1 << (k % 3));
`else
            exp_ack = 7'b0000001;
`endif
            chk($sformatf("s2_grant%0d", k), 64'(ack_s), 64'(exp_ack));
        end
        idle();

        // Three-cycle resend during streaming.
        do_reset();
        cfg(1, 3, 2);
        exp_addr = 0;
        for (int k = 0; k < 10; k++) begin
            bus.resend = (k >= 4 && k < 7);
            drive(7'b0000001, 32'(k), 0);
            cycle(ack_s);
            if (k >= 4 && k < 7) begin
                chk("s3_ack_resend", 64'(ack_s), 64'd0);
                chk("s3_dout_resend", 64'(bus.dout_leaf_interface2bft), 64'd0);
            end else begin
                chk("s3_ack", 64'(ack_s), 64'd1);
                chk("s3_dout", 64'(bus.dout_leaf_interface2bft), 64'(mkpkt(3, 2, exp_addr, 32'(k))));
                exp_addr++;
            end
        end
        idle();

        // Port 2 at zero credit with simultaneous credit return and valid.
        do_reset();
        cfg(2, 4, 6);
        grants = 0;
        for (int c = 0; c < 128; c++) begin
            drive(7'b0000010, 0, 32'(c));
            cycle(ack_s);
            if (ack_s[1]) grants++;
        end
        chk("s4_drain", 64'(grants), 64'd128);
        credit_vld = 1'b1; credit_port = 4'd2;
        drive(7'b0000010, 0, 32'hBEEF);
        cycle(ack_s);
        chk("s4_ack_same_cycle", 64'(ack_s), 64'd0);
        credit_vld = 1'b0;
        cycle(ack_s);
        chk("s4_ack_next", 64'(ack_s), 64'b0000010);
        chk("s4_dout_next", 64'(bus.dout_leaf_interface2bft), 64'(mkpkt(4, 6, 0, 32'hBEEF)));
        grants = 0;
        for (int c = 0; c < 80; c++) begin
            cycle(ack_s);
            if (ack_s[1]) grants++;
        end
        chk("s4_remaining_credit", 64'(grants), 64'd63);
        idle();

        // Reset while streaming.
        do_reset();
        cfg(1, 3, 2);
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            drive(7'b0000001, 32'(c), 0);
            cycle(ack_s);
            if (ack_s[0]) grants++;
        end
        chk("s5_prestream", 64'(grants), 64'd10);
        reset = 1'b1;
        cycle(ack_s);
        chk("s5_ack_in_reset", 64'(ack_s), 64'd0);
        chk("s5_dout_after_reset", 64'(bus.dout_leaf_interface2bft), 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle(ack_s);
            chk("s5_unconfigured_ack", 64'(ack_s), 64'd0);
            chk("s5_unconfigured_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        end
        cfg_we = 1'b1; cfg_port = 4'd1; cfg_leaf = 5'd2; cfg_dport = 4'd1;
        drive(7'b0000001, 32'h77, 0);
        cycle(ack_s);
        chk("s5_ack_cfg_cycle", 64'(ack_s), 64'd0);
        cfg_we = 1'b0;
        cycle(ack_s);
        chk("s5_ack_after_cfg", 64'(ack_s), 64'd1);
        chk("s5_dout_after_cfg", 64'(bus.dout_leaf_interface2bft), 64'(mkpkt(2, 1, 0, 32'h77)));
        grants = 1;
        for (int c = 0; c < 140; c++) begin
            cycle(ack_s);
            if (ack_s[0]) grants++;
        end
        chk("s5_full_credit", 64'(grants), 64'd128);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
